spi_flash_block_sched: RTL
==========================

# spi_flash_block_sched

Block-read scheduler that shares the single SPI flash block controller (`spi_flash_ctrl`) and its 1024-byte block BRAM between NREQ requesters, e.g. the Wishbone flash window and the boot loader. Round-robin arbitration. Holds a one-entry block tag, so a request for the block already in BRAM completes without SPI traffic. Guards each SPI block read with a timeout. Sits between the requesters and `spi_flash_ctrl`; `o_grant` also steers the BRAM read-port mux outside this block.

## Interface
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 24, flash byte-address width
- BLOCK_BITS, 10, log2 of block size in bytes
- TIMEOUT, 65535, maximum WAIT cycles before a read is aborted with error
- i_clk  in  1  clock; the only clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req  in  NREQ  per-requester level request; held until `o_done`
- i_req_addr  in  NREQ*ADDR_W  per-requester byte address; requester k at bits [k*ADDR_W +: ADDR_W]
- o_grant  out  NREQ  one-hot owner; all zero when idle
- o_done  out  NREQ  one-cycle completion pulse to the owner
- o_err  out  NREQ  one-cycle error pulse; coincident with `o_done` on timeout
- o_read_addr  out  ADDR_W  block-aligned address to the controller
- o_read_stb  out  1  one-cycle start strobe to the controller
- i_read_done_stb  in  1  controller block-complete strobe
- i_invalidate  in  1  clears the tag valid bit (flash was written or erased)
- o_busy  out  1  high in every state except IDLE

## Operation
- State machine: IDLE, LOOKUP, ISSUE, WAIT, DONE. Encoding is 3-bit; unused codes go to IDLE.
- **IDLE**
  - If any `i_req` bit is set, the arbiter picks the first set bit at or after `rr_ptr`, wrapping at NREQ.
  - Registers the winner into `o_grant`.
  - Latches `blk = i_req_addr[winner][ADDR_W-1:BLOCK_BITS]`.
  - Goes to LOOKUP.
- **LOOKUP**
  - Hit is `tag_valid && tag == blk`.
  - Hit: go to DONE. Miss: go to ISSUE.
- **ISSUE**
  - `o_read_stb` = 1 for this one cycle.
  - `o_read_addr = {blk, BLOCK_BITS'b0}`; it holds this value until DONE ends.
  - Clears `tag_valid`, because the BRAM is now being overwritten.
  - Clears the timeout counter. Goes to WAIT.
- **WAIT**
  - Counter width is $clog2(TIMEOUT+1). The counter increments once per WAIT cycle.
  - On `i_read_done_stb`: `tag <= blk`, `tag_valid <= 1`, go to DONE.
  - If `i_read_done_stb` is absent and the count equals TIMEOUT: set the error flag, leave `tag_valid` at 0, go to DONE.
- **DONE**
  - `o_done[owner]` = 1 for one cycle; `o_err[owner]` = error flag.
  - `rr_ptr <= (owner+1) mod NREQ`.
  - `o_grant` clears at the end of the cycle. Goes to IDLE.
- Requesters must drop `i_req` in the cycle after `o_done`.
- Boundary rules:
  - A requester that drops `i_req` mid-operation does not abort it. The read completes, the tag updates and `o_done` still pulses.
  - `i_read_done_stb` outside WAIT is ignored.
  - `i_read_done_stb` and timeout in the same cycle: done wins, no error.
  - `i_invalidate` in any state clears `tag_valid`. This includes the same cycle as `i_read_done_stb`, where invalidate wins and the tag stays invalid.
  - `i_invalidate` during LOOKUP forces a miss.
  - Address bits below BLOCK_BITS are ignored for both tag compare and `o_read_addr`.
- Reset, asynchronous and taking effect immediately, including mid-read:
  - State goes to IDLE; all outputs are 0.
  - `tag_valid`, `rr_ptr`, counter and error flag go to 0.
  - A controller read still in flight may later strobe done; that strobe is ignored in IDLE.

## Timing
- Request seen in IDLE at cycle 0: `o_grant` is high from cycle 1.
- Hit: `o_done` in cycle 2, latency 2, no `o_read_stb`.
- Miss: `o_read_stb` in cycle 2. `o_done` is one cycle after the cycle in which `i_read_done_stb` is sampled.
- Timeout: `o_done` and `o_err` pulse TIMEOUT+2 cycles after `o_read_stb`.
- Back-to-back requests: one IDLE cycle between operations, so there is at least 3 cycles per grant.

## Structure
- Shared package `spi_flash_pkg`: state encodings, default ADDR_W and BLOCK_BITS. Reused by `spi_flash_ctrl` and `wb_spi_flash_ctrl`.
- Sub-module `spi_flash_rr_arb`: combinational round-robin pick.
  - Inputs: `req[NREQ]`, `ptr`.
  - Output: one-hot `gnt`.
  - Reused later for other arbitration.

## Test plan
- Cold miss: reset, then `i_req`=2'b01 with addr 0x012345. Expect `o_grant`=01 from cycle 1, `o_read_stb` in cycle 2 with `o_read_addr`=0x012000. Drive `i_read_done_stb` 20 cycles later; expect `o_done`=01 next cycle and `o_err`=0.
- Hit: after the cold miss, requester 1 requests addr 0x0123FF. Expect `o_done`=10 in cycle 2 and no `o_read_stb`.
- Fairness: both requesters hold `i_req` continuously with different blocks. Expect grants alternating 01,10,01,10 over 4 operations, with exactly one `o_read_stb` per operation.
- Timeout: TIMEOUT=15, never strobe done. Expect `o_done`=`o_err`=01 at `o_read_stb`+17. Next request to the same block is a miss.
- Invalidate: assert `i_invalidate` together with `i_read_done_stb`. A repeat request to the same block must issue `o_read_stb`.
- Reset mid-WAIT: deassert `i_rst_n` 5 cycles after `o_read_stb`. Expect all outputs 0 immediately. After release, a stray `i_read_done_stb` produces no `o_done`.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash block path: FSM state encoding and
// default address geometry.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_BLOCK_BITS = 10;

endpackage

// File: rtl/spi_flash_rr_arb.sv
// Combinational round-robin pick: one-hot grant of the first set request at or
// after ptr, wrapping at NREQ.
module spi_flash_rr_arb #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  int unsigned      idx;
  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_flash_block_sched.sv
// Shares spi_flash_ctrl and its block BRAM between NREQ requesters, with a
// one-entry block tag and a timeout on every SPI block read.
module spi_flash_block_sched
  import spi_flash_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BLOCK_BITS = DEF_BLOCK_BITS,
  parameter int TIMEOUT    = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*ADDR_W-1:0] i_req_addr,
  output logic [NREQ-1:0]        o_grant,
  output logic [NREQ-1:0]        o_done,
  output logic [NREQ-1:0]        o_err,
  output logic [ADDR_W-1:0]      o_read_addr,
  output logic                   o_read_stb,
  input  logic                   i_read_done_stb,
  input  logic                   i_invalidate,
  output logic                   o_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int BLK_W = ADDR_W - BLOCK_BITS;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick;
  logic [BLK_W-1:0]  blk;
  logic [BLK_W-1:0]  pick_blk;
  logic [BLK_W-1:0]  tag;
  logic              tag_valid;
  logic [CNT_W-1:0]  cnt;
  logic              hit;
  logic              unused_addr_bits;

  spi_flash_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    pick_blk = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick[PTR_W'(k)]) begin
        pick_idx = PTR_W'(k);
        pick_blk = i_req_addr[k*ADDR_W + BLOCK_BITS +: BLK_W];
      end
    end
  end

  // Offset bits within a block never influence the scheduler.
  assign unused_addr_bits = ^i_req_addr;

  // An invalidate in the LOOKUP cycle itself must already force a miss.
  assign hit = tag_valid && !i_invalidate && (tag == blk);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      blk         <= '0;
      tag         <= '0;
      tag_valid   <= 1'b0;
      cnt         <= '0;
      o_grant     <= '0;
      o_done      <= '0;
      o_err       <= '0;
      o_read_addr <= '0;
      o_read_stb  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_read_stb <= 1'b0;
      o_done     <= '0;
      o_err      <= '0;
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            o_grant <= pick;
            owner   <= pick_idx;
            blk     <= pick_blk;
            o_busy  <= 1'b1;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            o_done <= o_grant;
            state  <= ST_DONE;
          end else begin
            o_read_stb  <= 1'b1;
            o_read_addr <= {blk, {BLOCK_BITS{1'b0}}};
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tag_valid <= 1'b0;
          cnt       <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_read_done_stb) begin
            tag       <= blk;
            tag_valid <= 1'b1;
            o_done    <= o_grant;
            state     <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            o_done <= o_grant;
            o_err  <= o_grant;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          rr_ptr      <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
          o_grant     <= '0;
          o_read_addr <= '0;
          o_busy      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          o_grant     <= '0;
          o_read_addr <= '0;
          o_busy      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
      if (i_invalidate) tag_valid <= 1'b0;
    end
  end

endmodule
